// File: rtl/chacha_pkg.sv
// Shared ChaCha definitions: word geometry, quarter-round index tables,
// rotation amounts, the "expand 32-byte k" constants and small helpers.
package chacha_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned NUM_WORDS = 16;
   localparam int unsigned STATE_W   = WORD_W * NUM_WORDS;

   typedef logic [WORD_W-1:0] word_t;

   // Quarter-round rotation amounts, in order of application
   localparam int unsigned ROT_1 = 16;
   localparam int unsigned ROT_2 = 12;
   localparam int unsigned ROT_3 = 8;
   localparam int unsigned ROT_4 = 7;

   // "expand 32-byte k"
   localparam word_t SIGMA_0 = 32'h61707865;
   localparam word_t SIGMA_1 = 32'h3320646e;
   localparam word_t SIGMA_2 = 32'h79622d32;
   localparam word_t SIGMA_3 = 32'h6b206574;

   // Word indices (a,b,c,d) of each quarter-round in a half-round group
   localparam logic [3:0] COL_IDX [4][4] = '{
      '{4'd0, 4'd4, 4'd8,  4'd12},
      '{4'd1, 4'd5, 4'd9,  4'd13},
      '{4'd2, 4'd6, 4'd10, 4'd14},
      '{4'd3, 4'd7, 4'd11, 4'd15}
   };
   localparam logic [3:0] DIAG_IDX [4][4] = '{
      '{4'd0, 4'd5, 4'd10, 4'd15},
      '{4'd1, 4'd6, 4'd11, 4'd12},
      '{4'd2, 4'd7, 4'd8,  4'd13},
      '{4'd3, 4'd4, 4'd9,  4'd14}
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Word i of a packed state lives at bits [32i+31:32i]
   function automatic word_t get_word(input logic [STATE_W-1:0] v, input int unsigned i);
      return v[WORD_W*i +: WORD_W];
   endfunction

   function automatic word_t rotl(input word_t v, input int unsigned n);
      return (v << n) | (v >> (WORD_W - n));
   endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter-round: add / xor / rotate by 16,12,8,7.
module chacha_qr
   import chacha_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [31:0] i_c,
   input  logic [31:0] i_d,
   output logic [31:0] o_a,
   output logic [31:0] o_b,
   output logic [31:0] o_c,
   output logic [31:0] o_d
);

   word_t w_a1, w_b1, w_c1, w_d1;
   word_t w_a2, w_b2, w_c2, w_d2;

   assign w_a1 = i_a + i_b;
   assign w_d1 = rotl(i_d ^ w_a1, ROT_1);
   assign w_c1 = i_c + w_d1;
   assign w_b1 = rotl(i_b ^ w_c1, ROT_2);
   assign w_a2 = w_a1 + w_b1;
   assign w_d2 = rotl(w_d1 ^ w_a2, ROT_3);
   assign w_c2 = w_c1 + w_d2;
   assign w_b2 = rotl(w_b1 ^ w_c2, ROT_4);

   assign o_a = w_a2;
   assign o_b = w_b2;
   assign o_c = w_c2;
   assign o_d = w_d2;

endmodule

// File: rtl/chacha_core.sv
// Iterative ChaCha block function: applies QR_UNITS quarter-rounds per
// cycle for ROUNDS rounds, then offers the (optionally feed-forward added)
// state on a valid/ready output.
module chacha_core
   import chacha_pkg::*;
#(
   parameter int unsigned ROUNDS       = 20,
   parameter int unsigned QR_UNITS     = 4,
   parameter int unsigned FEED_FORWARD = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [511:0] out_data,
   output logic         busy
);

   localparam int unsigned STEPS_PER_HALF = 4 / QR_UNITS;
   localparam int unsigned TOTAL_STEPS    = ROUNDS * STEPS_PER_HALF;
   localparam int unsigned CNT_W          = $clog2(TOTAL_STEPS);

   if ((ROUNDS % 2) != 0 || ROUNDS < 2) begin : g_bad_rounds
      $error("chacha_core: ROUNDS must be even and >= 2");
   end
   if (QR_UNITS != 1 && QR_UNITS != 2 && QR_UNITS != 4) begin : g_bad_qr_units
      $error("chacha_core: QR_UNITS must be 1, 2 or 4");
   end

   state_e           r_state;
   word_t            r_work [NUM_WORDS];
   word_t            r_orig [NUM_WORDS];
   logic [1:0]       r_step;
   logic             r_half;
   logic [CNT_W-1:0] r_cnt;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;

   logic [1:0]       w_q      [QR_UNITS];
   logic [3:0]       w_idx    [QR_UNITS][4];
   word_t            w_qr_in  [QR_UNITS][4];
   word_t            w_qr_out [QR_UNITS][4];
   word_t            w_work_next [NUM_WORDS];

   // Select the a/b/c/d operands of this step's quarter-rounds from work
   always_comb begin
      for (int unsigned u = 0; u < QR_UNITS; u++) begin
         w_q[u] = 2'((32'(r_step) * QR_UNITS) + u);
         for (int unsigned k = 0; k < 4; k++) begin
            w_idx[u][k]   = r_half ? DIAG_IDX[w_q[u]][k] : COL_IDX[w_q[u]][k];
            w_qr_in[u][k] = r_work[w_idx[u][k]];
         end
      end
   end

   for (genvar g = 0; g < QR_UNITS; g++) begin : g_qr
      chacha_qr u_qr (
         .i_a (w_qr_in[g][0]),
         .i_b (w_qr_in[g][1]),
         .i_c (w_qr_in[g][2]),
         .i_d (w_qr_in[g][3]),
         .o_a (w_qr_out[g][0]),
         .o_b (w_qr_out[g][1]),
         .o_c (w_qr_out[g][2]),
         .o_d (w_qr_out[g][3])
      );
   end

   // Merge quarter-round results back; words within one step never overlap
   always_comb begin
      w_work_next = r_work;
      for (int unsigned u = 0; u < QR_UNITS; u++) begin
         for (int unsigned k = 0; k < 4; k++) begin
            w_work_next[w_idx[u][k]] = w_qr_out[u][k];
         end
      end
   end

   // Output words: work plus original input when feed-forward is enabled
   always_comb begin
      out_data = '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         out_data[WORD_W*i +: WORD_W] = r_work[i] + ((FEED_FORWARD != 0) ? r_orig[i] : '0);
      end
   end

   // Control FSM with counters, state registers and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_step      <= '0;
         r_half      <= 1'b0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            r_work[i] <= '0;
            r_orig[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                     r_work[i] <= get_word(in_data, i);
                     r_orig[i] <= get_word(in_data, i);
                  end
                  r_step     <= '0;
                  r_half     <= 1'b0;
                  r_cnt      <= '0;
                  r_state    <= ST_RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            ST_RUN: begin
               r_work <= w_work_next;
               r_cnt  <= r_cnt + 1'b1;
               if (r_step == 2'(STEPS_PER_HALF - 1)) begin
                  r_step <= '0;
                  r_half <= ~r_half;
               end else begin
                  r_step <= r_step + 2'd1;
               end
               if (r_cnt == CNT_W'(TOTAL_STEPS - 1)) begin
                  r_state     <= ST_DONE;
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

endmodule
